// File: rtl/cu_sequencer_if.sv
// cu_sequencer_if: bundles the sequencer's control and status signals.
//   hold      : stall request; freezes the sequencer
//   OPCode    : opcode from the instruction register, valid in state 2
//   subiu     : per-channel "rose" handshake flags
//   desceu    : per-channel "fell" handshake flags
//   State     : registered current state
//   NextState : combinational state loaded at the next unheld edge
//   done      : one-cycle pulse, instruction completed normally
//   timeout   : one-cycle pulse, wait aborted by timeout
//   illegal   : one-cycle pulse, wait opcode on a nonexistent channel
// The master modport drives the request side; the slave modport is the
// sequencer itself.
interface cu_sequencer_if #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 3,
  parameter int NUM_CH   = 4
);
  logic                hold;
  logic [OPCODE_W-1:0] OPCode;
  logic [NUM_CH-1:0]   subiu;
  logic [NUM_CH-1:0]   desceu;
  logic [STATE_W-1:0]  State;
  logic [STATE_W-1:0]  NextState;
  logic                done;
  logic                timeout;
  logic                illegal;

  modport master (
    output hold, OPCode, subiu, desceu,
    input  State, NextState, done, timeout, illegal
  );

  modport slave (
    input  hold, OPCode, subiu, desceu,
    output State, NextState, done, timeout, illegal
  );
endinterface

// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle sequencer for the accumulator processor control
// unit. Owns the state register and next-state decode. The opcode is latched
// at the 2->3 edge and classified as SHORT (3->0), LONG (3->4->0), EXTENDED
// (3->4->5->0) or WAIT (handshake on channel op[1:0], held in 3 until the
// channel's rose/fell flags differ, then in 4 until they match again).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : cu_sequencer_if.slave (hold, OPCode, subiu, desceu in;
//           State, NextState, done, timeout, illegal out)
// Optional feature: define CU_TIMEOUT_EN to add a TIMEOUT_W-bit wait
// counter that aborts a stalled WAIT after 2^TIMEOUT_W cycles. Without it
// waits last indefinitely and timeout is tied low.
module cu_sequencer #(
  parameter int OPCODE_W  = 6,
  parameter int STATE_W   = 3,
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT_W = 8
) (
  input logic          clk,
  input logic          reset,
  cu_sequencer_if.slave bus
);

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH0 = STATE_W'(0),
    ST_FETCH1 = STATE_W'(1),
    ST_DECODE = STATE_W'(2),
    ST_EXEC3  = STATE_W'(3),
    ST_EXEC4  = STATE_W'(4),
    ST_EXEC5  = STATE_W'(5)
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [OPCODE_W-1:0] op_q;
  logic [5:0]          op6;
  logic [1:0]          ch;
  logic                is_long;
  logic                is_ext;
  logic                is_wait;
  logic                ch_valid;
  logic [3:0]          ch_diff;
  logic                sel_diff;
  logic                wait_stall;   // wait condition would keep the state
  logic                wait_active;  // in state 3/4 of a valid-channel WAIT
  logic                to_hit;
  logic                ill_hit;
  logic                leaving;
  logic                done_reg, timeout_reg, illegal_reg;
  logic                done_next, timeout_next, illegal_next;

  // Parameter sanity blocks; empty bodies, they only flag bad configurations
  // in elaboration reports by name.
  if (STATE_W < 3 || OPCODE_W < 6 || NUM_CH < 1 || NUM_CH > 4) begin : g_bad_params
  end
  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
  end

  // Classification on the top 6 bits of the latched opcode.
  assign op6 = op_q[OPCODE_W-1 -: 6];
  assign ch  = op6[1:0];
  assign ch_valid = (32'(ch) < 32'(NUM_CH));

  always_comb begin
    is_long = 1'b0;
    is_ext  = 1'b0;
    is_wait = 1'b0;
    case (op6)
      6'b011011, 6'b011100, 6'b011101, 6'b011110,
      6'b011111, 6'b100000, 6'b100001, 6'b101000: is_long = 1'b1;
      6'b100010:                                  is_ext  = 1'b1;
      default:                                    is_wait = (op6[5:2] == 4'b1111);
    endcase
  end

  // Per-channel "flags differ" vector, padded to 4 so any ch index is safe.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    if (gi < NUM_CH) begin : g_real
      assign ch_diff[gi] = bus.subiu[gi] ^ bus.desceu[gi];
    end else begin : g_pad
      assign ch_diff[gi] = 1'b0;
    end
  end
  assign sel_diff = ch_diff[ch];

  assign wait_active = is_wait && ch_valid &&
                       (state_reg == ST_EXEC3 || state_reg == ST_EXEC4);

`ifdef CU_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_reg;
  logic [TIMEOUT_W-1:0] cnt_next;

  assign cnt_next = wait_active ? cnt_reg + TIMEOUT_W'(1) : '0;
  // Counter at all-ones means this is the 2^TIMEOUT_W-th wait cycle.
  assign to_hit   = wait_stall && (cnt_reg == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (!bus.hold) begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_next = ST_FETCH0;
    wait_stall = 1'b0;
    case (state_reg)
      ST_FETCH0: state_next = ST_FETCH1;
      ST_FETCH1: state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC3;
      ST_EXEC3: begin
        if (is_wait) begin
          if (!ch_valid) begin
            state_next = ST_FETCH0;
          end else if (sel_diff) begin
            state_next = ST_EXEC4;
          end else begin
            state_next = ST_EXEC3;
            wait_stall = 1'b1;
          end
        end else if (is_long || is_ext) begin
          state_next = ST_EXEC4;
        end
      end
      ST_EXEC4: begin
        if (is_wait && ch_valid) begin
          if (sel_diff) begin
            state_next = ST_EXEC4;
            wait_stall = 1'b1;
          end
        end else if (is_ext) begin
          state_next = ST_EXEC5;
        end
      end
      default: state_next = ST_FETCH0;
    endcase
    // Timeout overrides a stalled wait.
    if (to_hit) begin
      state_next = ST_FETCH0;
    end
  end

  assign ill_hit = (state_reg == ST_EXEC3) && is_wait && !ch_valid;
  assign leaving = (state_reg >= ST_EXEC3) && (state_next == ST_FETCH0);

  // Pulses are only generated on edges that actually move the state.
  assign done_next    = !bus.hold && leaving && !to_hit && !ill_hit;
  assign timeout_next = !bus.hold && to_hit;
  assign illegal_next = !bus.hold && ill_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_FETCH0;
      op_q        <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      illegal_reg <= illegal_next;
      if (!bus.hold) begin
        state_reg <= state_next;
        if (state_reg == ST_DECODE) begin
          op_q <= bus.OPCode;
        end
      end
    end
  end

  assign bus.State     = state_reg;
  assign bus.NextState = state_next;
  assign bus.done      = done_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Registered, parametrised multi-cycle sequencer for the accumulator processor control unit. It owns the state register and the next-state decode. It latches the opcode at decode time and classifies it into short, long, extended or I/O-wait instruction classes. The I/O-wait class supports several handshake channels, with an optional wait timeout. It sits between the instruction register and the control-signal decoder, which consumes `State`.

## Interface
- `OPCODE_W`, 6: opcode width; the fixed opcode encodings below occupy the top 6 bits.
- `STATE_W`, 3: state register width; must be ≥ 3.
- `NUM_CH`, 4: number of I/O handshake channels (1..4).
- `TIMEOUT_W`, 8: wait-timeout counter width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `hold` in 1: freeze sequencer (stall).
- `OPCode` in OPCODE_W: opcode from instruction register, valid in state 2.
- `subiu` in NUM_CH: per-channel "rose" handshake flag.
- `desceu` in NUM_CH: per-channel "fell" handshake flag.
- `State` out STATE_W: registered current state.
- `NextState` out STATE_W: combinational state to be loaded at the next edge if `hold`=0.
- `done` out 1: registered one-cycle pulse, instruction completed normally.
- `timeout` out 1: registered one-cycle pulse, wait aborted by timeout.
- `illegal` out 1: registered one-cycle pulse, wait opcode on a nonexistent channel.

## Operation
- States 0, 1 and 2 are fetch/decode and always advance 0→1→2→3.
- At the 2→3 edge `OPCode` is latched into `op_q`. All classification from state 3 onward uses `op_q`.
- Classes are decoded on the top 6 bits of `op_q`:
  - LONG: 011011, 011100, 011101, 011110, 011111, 100000, 100001, 101000.
  - EXTENDED: 100010.
  - WAIT: 1111xx. Channel ch = bits [1:0].
  - SHORT: everything else.
- SHORT: 3→0.
- LONG: 3→4→0.
- EXTENDED: 3→4→5→0.
- WAIT with ch < NUM_CH:
  - In state 3: stay while `subiu[ch]`==`desceu[ch]`; go to 4 when they differ.
  - In state 4: stay while they differ; go to 0 when they are equal.
- WAIT with ch ≥ NUM_CH: 3→0 and `illegal` pulses.
- States 5 (non-EXTENDED), 6, 7 and any unused codes go to 0.
- `hold`=1 freezes `State`, `op_q` and the timeout counter. `done`, `timeout` and `illegal` are 0 during hold. `NextState` still shows the target.
- `done` is registered high for exactly one cycle after any normal transition into 0 from state ≥3.

## Timing
- Reset values: `State`=0, `op_q`=0, counter=0, `done`=0, `timeout`=0, `illegal`=0.
- Reset mid-instruction aborts immediately to state 0 with no `done` pulse.
- Minimum latencies: SHORT 4 cycles, LONG 5, EXTENDED 6, WAIT 5 (one cycle in each wait state).
- Handshake inputs are sampled combinationally into `NextState`. The caller synchronises them externally.
- Pulses (`done`, `timeout`, `illegal`) are high during the first cycle with `State`=0.
- `hold` asserted on the same edge as a completion delays the completion and its pulse until the first edge with `hold`=0.

## Configuration
- `CU_TIMEOUT_EN` defined:
  - The TIMEOUT_W counter increments each unheld cycle in state 3 or 4 of a WAIT instruction. It clears in every other state.
  - When the counter equals all-ones and the wait condition would hold the state, `NextState`=0 and the following cycle carries `timeout`=1 with `done`=0.
  - Maximum wait is 2^TIMEOUT_W cycles across states 3 and 4 combined.
- `CU_TIMEOUT_EN` undefined:
  - No counter is instantiated, and `timeout` is tied to 0.
  - Waits last indefinitely.

## Test plan
- Reset, then `OPCode`=000000 → `State` 0,1,2,3,0. `done`=1 in the 5th cycle only.
- `OPCode`=100010 → `State` 0,1,2,3,4,5,0. `done` pulses once. With `OPCode` changed to 000000 during state 3, the sequence is unchanged (latched `op_q`).
- `OPCode`=111101 (ch1), `subiu[1]`=`desceu[1]`=0 for 3 cycles in state 3, then `subiu[1]`=1 for 2 cycles, then `desceu[1]`=1 → 3 held three cycles, 4 held two cycles, then 0 with `done`.
- NUM_CH=2, `OPCode`=111111 → 3→0 with `illegal`=1 and `done`=0.
- `CU_TIMEOUT_EN`, TIMEOUT_W=4, WAIT ch0 with inputs never differing → state 3 for 16 cycles, then 0 with `timeout`=1.
- `hold`=1 for 3 cycles in state 4 of a LONG instruction → `State` stays 4 and `NextState`=0. Completion follows the hold release. Asserting `reset` in state 4 gives `State`=0 asynchronously with no pulses.
